mem_port_sched: RTL and testbench
=================================

MEM_PORT_SCHED -- requirements
Module: mem_port_sched

Interface
Parameters: none.
REQ-001 SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- if_address  in  16  fetch-stage PC
- if_rdata  out  16  latched instruction word
- d_read  in  1  data-stage load request
- d_write  in  1  data-stage store request
- d_address  in  16  data address
- d_wdata  in  16  store data
- d_byte_enable  in  2  store byte mask
- d_rdata  out  16  latched load data
- mem_read  out  1  physical port read strobe
- mem_write  out  1  physical port write strobe
- mem_address  out  16  physical port address
- mem_wdata  out  16  physical port write data
- mem_byte_enable  out  2  physical port byte mask
- mem_rdata  in  16  physical port read data
- mem_resp  in  1  physical port completion, one-cycle pulse
- ld_regs  out  1  one-cycle pulse; advances all pipeline registers
- stall_count  out  16  saturating count of non-advance cycles

Function
REQ-002 SHALL use FSM states IDLE, DATA, FETCH, ADVANCE.
REQ-003 IDLE: sample requests for one cycle; go to DATA if d_read|d_write, else to FETCH.
REQ-004 On leaving IDLE, SHALL capture if_address, d_address, d_wdata, d_byte_enable and the op (write if d_write, else read) into internal registers.
REQ-005 Port outputs SHALL come only from the captured registers. Input changes after capture SHALL NOT alter an in-flight access.
REQ-006 DATA: drive the captured data access (mem_write=1 for a store, mem_read=1 for a load). Hold it until mem_resp. On mem_resp: latch mem_rdata into d_rdata for loads, then go to FETCH.
REQ-007 FETCH: mem_read=1, mem_address=captured PC. Hold until mem_resp. On mem_resp: latch mem_rdata into if_rdata, then go to ADVANCE.
REQ-008 ADVANCE: ld_regs=1 for exactly one cycle, port strobes 0; next state IDLE.
REQ-009 Data access SHALL always precede fetch in the same step (older instruction first).
REQ-010 mem_read and mem_write SHALL never be 1 together.
REQ-011 d_read and d_write both 1: SHALL be treated as a store.
REQ-012 mem_resp in IDLE or ADVANCE SHALL be ignored with no state change.
REQ-013 if_rdata and d_rdata SHALL hold their value until next overwritten. d_rdata SHALL be unchanged by store steps.
REQ-014 Minimum step latency with zero-wait memory (mem_resp in the first strobe cycle) SHALL be 3 cycles without a data access (IDLE, FETCH, ADVANCE) and 4 cycles with one.
REQ-015 stall_count SHALL increment every cycle ld_regs=0, saturating at 16'hFFFF.
REQ-016 In idle port cycles, mem_address, mem_wdata and mem_byte_enable SHALL hold their last values.

Reset
REQ-017 reset_n=0 SHALL immediately force state IDLE, and set mem_read=0, mem_write=0, ld_regs=0, if_rdata=0, d_rdata=0, stall_count=0, mem_address=0, mem_wdata=0, mem_byte_enable=0.
REQ-018 Reset mid-access SHALL abandon the access with no ld_regs pulse. A mem_resp arriving after reset release while in IDLE SHALL be ignored per REQ-012.

Structure
REQ-019 lc3b_word and lc3b_mem_wmask SHALL come from the shared lc3b_types package. The FSM state enum SHALL be added to that package as lc3b_sched_state.
REQ-020 SHALL be a single module with no sub-modules. Output latches SHALL use the existing register module (width 16).
REQ-021 SHALL replace the arbiter instance in the top level and drive the shared load_regs net.

Verification
REQ-022 Fetch-only: if_address=16'h0010, d_read=d_write=0, mem_resp after 2 wait cycles, mem_rdata=16'h1234 -> one read at 16'h0010, if_rdata=16'h1234, ld_regs pulses once, no mem_write.
REQ-023 Load then fetch: d_read=1, d_address=16'h0200, if_address=16'h0012; rdata 16'hBEEF then 16'h6042 -> address order 16'h0200 then 16'h0012, d_rdata=16'hBEEF, if_rdata=16'h6042, one ld_regs pulse.
REQ-024 Store: d_write=1, d_address=16'h0300, d_wdata=16'hA5A5, d_byte_enable=2'b01 -> mem_write=1 with those exact values until mem_resp, then fetch read, d_rdata unchanged.
REQ-025 Stability and stray responses: change d_address to 16'hFFFF during a DATA wait -> mem_address stays 16'h0300; mem_resp pulsed in IDLE -> no state change.
REQ-026 Reset mid-FETCH: assert reset_n=0 during a wait -> strobes 0 on the same edge, no ld_regs; after release, next step completes normally and stall_count restarts from 0.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types: word and write-mask widths, plus the memory-port scheduler state.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DATA    = 2'd1,
        FETCH   = 2'd2,
        ADVANCE = 2'd3
    } lc3b_sched_state;

endpackage

// File: rtl/register.sv
// Generic loadable register with asynchronous active-low clear.
module register #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [width-1:0] din,
    output logic [width-1:0] dout
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= '0;
        end else if (load) begin
            dout <= din;
        end
    end

endmodule

// File: rtl/mem_port_sched.sv
// Single physical memory port shared by data and fetch stages: one data access (if any),
// then one instruction fetch, then a one-cycle pipeline advance pulse.
module mem_port_sched
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] if_address,
    output logic [15:0] if_rdata,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [15:0] d_address,
    input  logic [15:0] d_wdata,
    input  logic [1:0]  d_byte_enable,
    output logic [15:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [15:0] mem_address,
    output logic [15:0] mem_wdata,
    output logic [1:0]  mem_byte_enable,
    input  logic [15:0] mem_rdata,
    input  logic        mem_resp,
    output logic        ld_regs,
    output logic [15:0] stall_count
);

    lc3b_sched_state state, next_state;
    lc3b_word        pc_q;
    lc3b_word        stall_q;
    logic            op_write_q;
    logic            load_i;
    logic            load_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ld_regs    = 1'b0;
        load_i     = 1'b0;
        load_d     = 1'b0;
        case (state)
            IDLE: begin
                next_state = (d_read | d_write) ? DATA : FETCH;
            end
            DATA: begin
                mem_write = op_write_q;
                mem_read  = ~op_write_q;
                if (mem_resp) begin
                    load_d     = ~op_write_q;
                    next_state = FETCH;
                end
            end
            FETCH: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    load_i     = 1'b1;
                    next_state = ADVANCE;
                end
            end
            ADVANCE: begin
                ld_regs    = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Port address/data are loaded only at the edge that enters a driven state, so they
    // hold their last value through IDLE and ADVANCE and ignore late input changes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q            <= '0;
            op_write_q      <= 1'b0;
            mem_address     <= '0;
            mem_wdata       <= '0;
            mem_byte_enable <= '0;
        end else if (state == IDLE) begin
            pc_q       <= if_address;
            op_write_q <= d_write;
            if (d_read | d_write) begin
                mem_address     <= d_address;
                mem_wdata       <= d_wdata;
                mem_byte_enable <= d_byte_enable;
            end else begin
                mem_address <= if_address;
            end
        end else if (state == DATA && mem_resp) begin
            mem_address <= pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else if (!ld_regs && stall_q != '1) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_count = stall_q;

    register #(.width(16)) u_if_rdata (
        .clk   (clk),
        .rst_n (reset_n),
        .load  (load_i),
        .din   (mem_rdata),
        .dout  (if_rdata)
    );

    register #(.width(16)) u_d_rdata (
        .clk   (clk),
        .rst_n (reset_n),
        .load  (load_d),
        .din   (mem_rdata),
        .dout  (d_rdata)
    );

endmodule

// File: tb/tb_mem_port_sched.sv
// Self-checking bench for mem_port_sched: directed and randomized steps against a step-level model.
module tb_mem_port_sched;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [15:0] if_address = '0;
    logic [15:0] if_rdata;
    logic        d_read = 1'b0;
    logic        d_write = 1'b0;
    logic [15:0] d_address = '0;
    logic [15:0] d_wdata = '0;
    logic [1:0]  d_byte_enable = '0;
    logic [15:0] d_rdata;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;
    logic        ld_regs;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Step-level model of what the port should show
    logic [15:0] exp_addr, exp_wdata, exp_i, exp_d;
    logic [1:0]  exp_be;
    int          stall_m;

    mem_port_sched dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .if_address      (if_address),
        .if_rdata        (if_rdata),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_address       (d_address),
        .d_wdata         (d_wdata),
        .d_byte_enable   (d_byte_enable),
        .d_rdata         (d_rdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .ld_regs         (ld_regs),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add_stall(input int n);
        stall_m = (stall_m + n > 65535) ? 65535 : stall_m + n;
    endtask

    task automatic model_reset();
        exp_addr  = '0;
        exp_wdata = '0;
        exp_be    = '0;
        exp_i     = '0;
        exp_d     = '0;
        stall_m   = 0;
    endtask

    task automatic quiet_port(input string tag);
        chk({tag, "_rd"}, 16'(mem_read), 16'd0);
        chk({tag, "_wr"}, 16'(mem_write), 16'd0);
        chk({tag, "_addr"}, mem_address, exp_addr);
        chk({tag, "_wdata"}, mem_wdata, exp_wdata);
        chk({tag, "_be"}, 16'(mem_byte_enable), 16'(exp_be));
    endtask

    // One full step, entered while the DUT sits in IDLE.
    task automatic step(input logic [15:0] pc, input logic dr, input logic dw,
                        input logic [15:0] da, input logic [15:0] wdt, input logic [1:0] be,
                        input int wd, input int wf, input logic [15:0] rd, input logic [15:0] rf,
                        input logic stray);
        logic has_data;
        logic wr;
        has_data = dr | dw;
        wr = dw;

        quiet_port("idle");
        chk("idle_ld", 16'(ld_regs), 16'd0);
        if_address = pc; d_read = dr; d_write = dw;
        d_address = da; d_wdata = wdt; d_byte_enable = be;
        mem_resp = stray; mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        if_address = ~pc; d_address = 16'hFFFF; d_wdata = ~wdt; d_byte_enable = ~be;
        d_read = 1'($urandom); d_write = 1'($urandom);
        add_stall(1);

        if (has_data) begin
            exp_addr = da; exp_wdata = wdt; exp_be = be;
            for (int w = 0; w <= wd; w++) begin
                chk("data_rd", 16'(mem_read), 16'(!wr));
                chk("data_wr", 16'(mem_write), 16'(wr));
                chk("data_addr", mem_address, exp_addr);
                chk("data_ld", 16'(ld_regs), 16'd0);
                if (wr) begin
                    chk("data_wdata", mem_wdata, exp_wdata);
                    chk("data_be", 16'(mem_byte_enable), 16'(exp_be));
                end
                if (w == wd) begin
                    mem_resp = 1'b1; mem_rdata = rd;
                end
                @(posedge clk); #1;
                mem_resp = 1'b0;
            end
            if (!wr) exp_d = rd;
            add_stall(wd + 1);
        end

        exp_addr = pc;
        for (int w = 0; w <= wf; w++) begin
            chk("fetch_rd", 16'(mem_read), 16'd1);
            chk("fetch_wr", 16'(mem_write), 16'd0);
            chk("fetch_addr", mem_address, exp_addr);
            chk("fetch_ld", 16'(ld_regs), 16'd0);
            chk("fetch_drdata", d_rdata, exp_d);
            if (w == wf) begin
                mem_resp = 1'b1; mem_rdata = rf;
            end
            @(posedge clk); #1;
            mem_resp = 1'b0;
        end
        exp_i = rf;
        add_stall(wf + 1);

        chk("adv_ld", 16'(ld_regs), 16'd1);
        quiet_port("adv");
        chk("adv_irdata", if_rdata, exp_i);
        chk("adv_drdata", d_rdata, exp_d);
        chk("adv_stall", stall_count, 16'(stall_m));
        mem_resp = stray; mem_rdata = 16'($urandom);
        @(posedge clk); #1;
        mem_resp = 1'b0;
        chk("post_ld", 16'(ld_regs), 16'd0);
        chk("post_irdata", if_rdata, exp_i);
        chk("post_drdata", d_rdata, exp_d);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ld"}, 16'(ld_regs), 16'd0);
        chk({tag, "_irdata"}, if_rdata, 16'd0);
        chk({tag, "_drdata"}, d_rdata, 16'd0);
        chk({tag, "_stall"}, stall_count, 16'd0);
        quiet_port(tag);
    endtask

    initial begin
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_reset_vals("rst");
        @(posedge clk); @(posedge clk); #1;
        check_reset_vals("rst_hold");
        @(negedge clk); reset_n = 1'b1;

        // Fetch only, two wait cycles
        step(16'h0010, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 0, 2, 16'h0000, 16'h1234, 1'b0);
        // Load then fetch
        step(16'h0012, 1'b1, 1'b0, 16'h0200, 16'h0000, 2'b11, 1, 1, 16'hBEEF, 16'h6042, 1'b0);
        // Store; d_address forced to FFFF during the wait
        step(16'h0014, 1'b0, 1'b1, 16'h0300, 16'hA5A5, 2'b01, 3, 0, 16'h7777, 16'h2222, 1'b0);
        // Read and write together act as a store
        step(16'h0016, 1'b1, 1'b1, 16'h0400, 16'h5A5A, 2'b10, 0, 0, 16'h9999, 16'h3333, 1'b0);
        // Zero-wait minimum latency, with stray responses in IDLE and ADVANCE
        step(16'h0018, 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 0, 0, 16'h0000, 16'h4444, 1'b1);
        step(16'h001A, 1'b1, 1'b0, 16'h0500, 16'h0000, 2'b00, 0, 0, 16'hCAFE, 16'h5555, 1'b1);

        for (int k = 0; k < 30; k++) begin
            step(16'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom),
                 2'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 16'($urandom), 16'($urandom), 1'($urandom));
        end

        // Reset in the middle of a fetch wait
        if_address = 16'h0020; d_read = 1'b0; d_write = 1'b0;
        @(posedge clk); #1;
        chk("mid_fetch_rd", 16'(mem_read), 16'd1);
        chk("mid_fetch_addr", mem_address, 16'h0020);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_reset_vals("mid_rst");
        @(posedge clk); #1;
        check_reset_vals("mid_rst_hold");
        @(negedge clk);
        mem_resp = 1'b1; mem_rdata = 16'hDEAD;
        reset_n = 1'b1;
        step(16'h0022, 1'b1, 1'b0, 16'h0600, 16'h0000, 2'b00, 1, 1, 16'h0F0F, 16'hF0F0, 1'b1);

        // Long waits drive stall_count into saturation
        for (int k = 0; k < 32; k++) begin
            step(16'h0100 + 16'(k), 1'b0, 1'b0, 16'h0000, 16'h0000, 2'b00, 0, 2100,
                 16'h0000, 16'(k), 1'b0);
        end
        step(16'h0200, 1'b1, 1'b0, 16'h0700, 16'h0000, 2'b00, 0, 0, 16'h1111, 16'h2222, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
